stopwatch_bcd_ctrl: RTL and testbench
=====================================

// Module: stopwatch_bcd_ctrl
// PURPOSE
//   Parametrised stopwatch core: run/pause/done controller, N-digit BCD up/down counter with preset load, and a digit-scan display mux.
//   Sits between the debounced button pulses and the board 7-segment pins; counting and scanning are clock-enable ticks on one clock.
// PARAMETERS
//   DIGITS      4   number of BCD digits counted and scanned (2..8)
//   LOAD_DIGITS 2   upper digits taken from load in preset modes (1..DIGITS)
//   DP_POS      2   digit index whose decimal point is lit (0 = rightmost)
// PORTS
//   c_clk      in   1          system clock
//   rst_n      in   1          asynchronous active-low reset
//   count_tick in   1          1-cycle count enable (e.g. 100 Hz)
//   scan_tick  in   1          1-cycle display-advance enable
//   start_p    in   1          1-cycle start/pause pulse
//   clear_p    in   1          1-cycle clear pulse
//   lap_p      in   1          1-cycle lap pulse (LAP_EN only)
//   sel        in   2          mode: 0 up from 0, 1 up from load, 2 down from all-9, 3 down from load
//   load       in   4*LOAD_DIGITS  BCD preset for the upper digits
//   count      out  4*DIGITS   live BCD count
//   state      out  2          00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   done       out  1          high in DONE
//   an         out  DIGITS     one-hot active-high digit enable
//   sseg       out  7          segments of the scanned digit (via hexto7segment)
//   dp         out  1          active low; 0 only when the scanned digit is DP_POS
// BEHAVIOUR
//   Reset: state=IDLE, count=0, mode_q=0, scan idx=0, an=1, dp=1, lap hold off.
//   IDLE: count is preset every cycle from the live sel: 0 / {load, 0s} / all 9s / {load, 0s}.
//   Load digits >9 clamp to 9.
//   A start_p in IDLE latches sel into mode_q and moves to RUN. sel is ignored outside IDLE.
//   RUN: on count_tick, count steps by 1 in mode_q direction with BCD carry/borrow across all digits.
//   Terminal value: all 9s (up) or all 0s (down). A count_tick with count already at terminal
//   goes to DONE with count unchanged. The counter never wraps.
//   The terminal value is displayed for one full tick before DONE.
//   Transitions: RUN start_p -> PAUSE; PAUSE start_p -> RUN; DONE ignores start_p.
//   clear_p from any state -> IDLE; the preset appears the next cycle.
//   Priority: clear_p > start_p > count_tick terminal check.
//   If start_p and count_tick coincide in RUN: pause, no count. In PAUSE: resume, no count this cycle.
//   Counter update latency: 1 cycle after count_tick. state/done are registered.
//   Scan: on scan_tick, idx = (idx==DIGITS-1) ? 0 : idx+1. an, dp and sseg are combinational from idx.
//   Scan is independent of state and runs in IDLE and DONE.
// CONFIGURATION
//   LAP_EN defined: lap_p in RUN or PAUSE toggles lap hold.
//     Entering hold copies count into lap_q; while held, sseg shows lap_q and the counter keeps running.
//     clear_p, DONE entry and reset drop the hold.
//   LAP_EN undefined: lap_p ignored; no lap_q register; sseg always shows count.
// STRUCTURE
//   Package stopwatch_pkg: state encodings (ST_IDLE/RUN/PAUSE/DONE), mode encodings (MODE_UP0, MODE_UPLD, MODE_DN9, MODE_DNLD), BCD_NINE.
//   Sub-module bcd_digit: one 4-bit BCD cell with en, up, load, carry/borrow in and out, and terminal flag.
//     Instantiated DIGITS times in a generate loop.
//   Existing hexto7segment is reused for sseg.
// TESTING
//   Mode 0, start, 150 ticks -> count=0150, state=RUN; start_p -> PAUSE; 10 ticks -> count stays 0150.
//   Mode 1, load=8'h99, start, 99 ticks -> 9999; next tick -> DONE, count=9999, done=1; start_p ignored.
//   Mode 3, load=8'h00, start, tick -> DONE, count=0000; clear_p -> IDLE with count=0000 next cycle.
//   Mode 2: 0000->... check borrow 9000 -> 8999 across all digits.
//   Change sel in RUN -> no effect; rst_n low mid-RUN -> async clear to IDLE, an=0001.
//   Scan: DIGITS=6, DP_POS=2, 7 scan_ticks -> an walks 000001..100000 -> 000010; dp=0 only on 000100.
//   LAP_EN: lap_p at 0042, 20 ticks -> sseg shows 0042 digits, count=0062; lap_p -> live display.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings and helpers for the stopwatch core.
// Optional lap-hold display is enabled by defining LAP_EN.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      MODE_UP0  = 2'b00,
      MODE_UPLD = 2'b01,
      MODE_DN9  = 2'b10,
      MODE_DNLD = 2'b11
   } mode_t;

   localparam logic [3:0] BCD_NINE = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   // Preset digits above nine are treated as nine so the counter never holds an illegal code.
   function automatic logic [3:0] bcdClamp(input logic [3:0] digit);
      return (digit > BCD_NINE) ? BCD_NINE : digit;
   endfunction

   function automatic logic modeIsUp(input mode_t mode);
      return (mode == MODE_UP0) || (mode == MODE_UPLD);
   endfunction

endpackage

// File: rtl/hexto7segment.sv
// Hex nibble to 7-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module hexto7segment (
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = 7'h7F;
      case (i_hex)
         4'h0: o_seg = 7'h40;
         4'h1: o_seg = 7'h79;
         4'h2: o_seg = 7'h24;
         4'h3: o_seg = 7'h30;
         4'h4: o_seg = 7'h19;
         4'h5: o_seg = 7'h12;
         4'h6: o_seg = 7'h02;
         4'h7: o_seg = 7'h78;
         4'h8: o_seg = 7'h00;
         4'h9: o_seg = 7'h10;
         4'hA: o_seg = 7'h08;
         4'hB: o_seg = 7'h03;
         4'hC: o_seg = 7'h46;
         4'hD: o_seg = 7'h21;
         4'hE: o_seg = 7'h06;
         4'hF: o_seg = 7'h0E;
         default: o_seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/stopwatch_bcd_ctrl_digit.sv
// One BCD counter cell; digits chain through i_cin/o_cout so a step ripples
// only while every lower digit sits at its terminal value for the direction.
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic       c_clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic       i_up,
   input  logic       i_load,
   input  logic [3:0] i_loadVal,
   input  logic       i_cin,
   output logic [3:0] o_q,
   output logic       o_cout,
   output logic       o_term
);

   logic [3:0] r_q;

   always_ff @(posedge c_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= BCD_ZERO;
      end else if (i_load) begin
         r_q <= i_loadVal;
      end else if (i_en && i_cin) begin
         if (i_up) begin
            r_q <= (r_q == BCD_NINE) ? BCD_ZERO : r_q + 4'd1;
         end else begin
            r_q <= (r_q == BCD_ZERO) ? BCD_NINE : r_q - 4'd1;
         end
      end
   end

   assign o_term = i_up ? (r_q == BCD_NINE) : (r_q == BCD_ZERO);
   assign o_cout = i_cin & o_term;
   assign o_q    = r_q;

endmodule

// File: rtl/stopwatch_bcd_ctrl.sv
// Stopwatch core: run/pause/done control, BCD up/down counter with preset and digit-scan mux.
// Define LAP_EN to add a lap-hold register that freezes the displayed value.
module stopwatch_bcd_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int LOAD_DIGITS = 2,
   parameter int DP_POS      = 2
) (
   input  logic                     c_clk,
   input  logic                     rst_n,
   input  logic                     count_tick,
   input  logic                     scan_tick,
   input  logic                     start_p,
   input  logic                     clear_p,
   input  logic                     lap_p,
   input  logic [1:0]               sel,
   input  logic [4*LOAD_DIGITS-1:0] load,
   output logic [4*DIGITS-1:0]      count,
   output logic [1:0]               state,
   output logic                     done,
   output logic [DIGITS-1:0]        an,
   output logic [6:0]               sseg,
   output logic                     dp
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t                r_state;
   mode_t                 r_mode;
   logic                  r_done;
   logic [IDX_W-1:0]      r_idx;

   mode_t                 w_selMode;
   logic                  w_up;
   logic                  w_load;
   logic                  w_step;
   logic                  w_toDone;
   logic                  w_terminal;
   logic [DIGITS:0]       w_carry;
   logic [DIGITS-1:0]     w_term;
   logic [4*DIGITS-1:0]   w_count;
   logic [4*DIGITS-1:0]   w_display;
   logic [3:0]            w_scanDigit;
   logic [DIGITS-1:0]     w_anOne;
   logic                  w_unusedCarry;

   assign w_selMode  = mode_t'(sel);
   assign w_up       = modeIsUp(r_mode);
   assign w_terminal = &w_term;
   assign w_carry[0] = 1'b1;
   assign w_unusedCarry = w_carry[DIGITS];

   // Clear reloads in the same edge so the preset is visible together with IDLE.
   assign w_load   = (r_state == ST_IDLE) || clear_p;
   assign w_step   = (r_state == ST_RUN) && count_tick && !start_p && !clear_p && !w_terminal;
   assign w_toDone = (r_state == ST_RUN) && count_tick && !start_p && !clear_p && w_terminal;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] w_presetDigit;

      if (i >= DIGITS - LOAD_DIGITS) begin : g_loaded
         assign w_presetDigit = (w_selMode == MODE_UP0) ? BCD_ZERO :
                                (w_selMode == MODE_DN9) ? BCD_NINE :
                                bcdClamp(load[4*(i-(DIGITS-LOAD_DIGITS)) +: 4]);
      end else begin : g_fixed
         assign w_presetDigit = (w_selMode == MODE_DN9) ? BCD_NINE : BCD_ZERO;
      end

      bcd_digit u_digit (
         .c_clk     (c_clk),
         .rst_n     (rst_n),
         .i_en      (w_step),
         .i_up      (w_up),
         .i_load    (w_load),
         .i_loadVal (w_presetDigit),
         .i_cin     (w_carry[i]),
         .o_q       (w_count[4*i +: 4]),
         .o_cout    (w_carry[i+1]),
         .o_term    (w_term[i])
      );
   end

   // Control FSM; the terminal value is shown for a whole tick before DONE is entered.
   always_ff @(posedge c_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_UP0;
         r_done  <= 1'b0;
      end else if (clear_p) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start_p) begin
                  r_mode  <= w_selMode;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (start_p) begin
                  r_state <= ST_PAUSE;
               end else if (w_toDone) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_PAUSE: begin
               if (start_p) begin
                  r_state <= ST_RUN;
               end
            end
            ST_DONE: begin
               r_done <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge c_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (scan_tick) begin
         if (r_idx == IDX_W'(DIGITS-1)) begin
            r_idx <= '0;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

`ifdef LAP_EN
   logic                r_lapHold;
   logic [4*DIGITS-1:0] r_lapQ;

   // Lap hold only freezes the display; the counter keeps running underneath.
   always_ff @(posedge c_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lapHold <= 1'b0;
         r_lapQ    <= '0;
      end else if (clear_p || w_toDone) begin
         r_lapHold <= 1'b0;
      end else if (lap_p && ((r_state == ST_RUN) || (r_state == ST_PAUSE))) begin
         r_lapHold <= !r_lapHold;
         if (!r_lapHold) begin
            r_lapQ <= w_count;
         end
      end
   end

   assign w_display = r_lapHold ? r_lapQ : w_count;
`else
   logic w_unusedLap;

   assign w_unusedLap = lap_p;
   assign w_display   = w_count;
`endif

   assign w_anOne     = {{(DIGITS-1){1'b0}}, 1'b1};
   assign an          = w_anOne << r_idx;
   assign dp          = (r_idx == IDX_W'(DP_POS)) ? 1'b0 : 1'b1;
   assign w_scanDigit = w_display[4*r_idx +: 4];

   hexto7segment u_seg (
      .i_hex (w_scanDigit),
      .o_seg (sseg)
   );

   assign count = w_count;
   assign state = r_state;
   assign done  = r_done;

endmodule

// File: tb/tb_stopwatch_bcd_ctrl.sv
// Directed vector bench for stopwatch_bcd_ctrl plus a 6-digit instance for the scan walk.
// Lap-hold expectations follow LAP_EN when it is defined for the build.
module tb_stopwatch_bcd_ctrl;

   typedef struct {
      logic [1:0]  sel;
      logic [7:0]  load;
      logic        clr;
      logic        st;
      int          ticks;
      logic [15:0] expCount;
      logic [1:0]  expState;
      logic        expDone;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic        countTick, scanTick, startP, clearP, lapP;
   logic [1:0]  sel;
   logic [7:0]  load;
   logic [15:0] count;
   logic [1:0]  state;
   logic        done;
   logic [3:0]  an;
   logic [6:0]  sseg;
   logic        dp;

   logic        scanTick6;
   logic [23:0] count6;
   logic [1:0]  state6;
   logic        done6;
   logic [5:0]  an6;
   logic [6:0]  sseg6;
   logic        dp6;

   int compareCount = 0;
   int failCount    = 0;
   int scanIdx      = 0;
   vec_t vecs[20];

   always #5 clk = ~clk;

   stopwatch_bcd_ctrl #(.DIGITS(4), .LOAD_DIGITS(2), .DP_POS(2)) dut (
      .c_clk(clk), .rst_n(rstN), .count_tick(countTick), .scan_tick(scanTick),
      .start_p(startP), .clear_p(clearP), .lap_p(lapP), .sel(sel), .load(load),
      .count(count), .state(state), .done(done), .an(an), .sseg(sseg), .dp(dp)
   );

   stopwatch_bcd_ctrl #(.DIGITS(6), .LOAD_DIGITS(2), .DP_POS(2)) dut6 (
      .c_clk(clk), .rst_n(rstN), .count_tick(1'b0), .scan_tick(scanTick6),
      .start_p(1'b0), .clear_p(1'b0), .lap_p(1'b0), .sel(2'b00), .load(8'h00),
      .count(count6), .state(state6), .done(done6), .an(an6), .sseg(sseg6), .dp(dp6)
   );

   function automatic logic [6:0] segOf(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseStart();
      startP = 1'b1; cycle(); startP = 1'b0;
   endtask

   task automatic pulseClear();
      clearP = 1'b1; cycle(); clearP = 1'b0;
   endtask

   task automatic pulseLap();
      lapP = 1'b1; cycle(); lapP = 1'b0;
   endtask

   task automatic ticks(input int n);
      countTick = 1'b1;
      repeat (n) cycle();
      countTick = 1'b0;
   endtask

   task automatic scanStep();
      scanTick = 1'b1; cycle(); scanTick = 1'b0;
      scanIdx = (scanIdx == 3) ? 0 : scanIdx + 1;
   endtask

   task automatic checkCore(input string name, input logic [15:0] c, input logic [1:0] s, input logic d);
      checkOutput({name, " count"}, 32'(count), 32'(c));
      checkOutput({name, " state"}, 32'(state), 32'(s));
      checkOutput({name, " done"},  32'(done),  32'(d));
   endtask

   // Walks all four digit positions and compares an/dp/sseg against the expected shown value.
   task automatic checkDisplay(input string name, input logic [15:0] value);
      logic [3:0] expAn;
      for (int k = 0; k < 4; k++) begin
         expAn = 4'b0001 << scanIdx;
         checkOutput({name, " an"},   32'(an),   32'(expAn));
         checkOutput({name, " dp"},   32'(dp),   32'((scanIdx == 2) ? 1'b0 : 1'b1));
         checkOutput({name, " sseg"}, 32'(sseg), 32'(segOf(value[4*scanIdx +: 4])));
         scanStep();
      end
   endtask

   task automatic applyStimulus(input int n, input vec_t v);
      sel  = v.sel;
      load = v.load;
      cycle();
      if (v.clr) pulseClear();
      if (v.st)  pulseStart();
      if (v.ticks > 0) ticks(v.ticks);
      cycle();
      checkCore($sformatf("vec%0d", n), v.expCount, v.expState, v.expDone);
   endtask

   initial begin
      logic [5:0] expAn6;
      //          sel    load   clr   st    ticks  count     state  done
      vecs[0]  = '{2'd0, 8'h00, 1'b1, 1'b0, 0,     16'h0000, 2'b00, 1'b0};
      vecs[1]  = '{2'd1, 8'h12, 1'b0, 1'b0, 0,     16'h1200, 2'b00, 1'b0};
      vecs[2]  = '{2'd1, 8'hA3, 1'b0, 1'b0, 0,     16'h9300, 2'b00, 1'b0};
      vecs[3]  = '{2'd2, 8'h00, 1'b0, 1'b0, 0,     16'h9999, 2'b00, 1'b0};
      vecs[4]  = '{2'd0, 8'h00, 1'b0, 1'b1, 150,   16'h0150, 2'b01, 1'b0};
      vecs[5]  = '{2'd0, 8'h00, 1'b0, 1'b1, 10,    16'h0150, 2'b10, 1'b0};
      vecs[6]  = '{2'd0, 8'h00, 1'b0, 1'b1, 5,     16'h0155, 2'b01, 1'b0};
      vecs[7]  = '{2'd3, 8'h55, 1'b0, 1'b0, 1,     16'h0156, 2'b01, 1'b0};
      vecs[8]  = '{2'd1, 8'h99, 1'b1, 1'b0, 0,     16'h9900, 2'b00, 1'b0};
      vecs[9]  = '{2'd1, 8'h99, 1'b0, 1'b1, 99,    16'h9999, 2'b01, 1'b0};
      vecs[10] = '{2'd1, 8'h99, 1'b0, 1'b0, 1,     16'h9999, 2'b11, 1'b1};
      vecs[11] = '{2'd1, 8'h99, 1'b0, 1'b1, 0,     16'h9999, 2'b11, 1'b1};
      vecs[12] = '{2'd1, 8'h99, 1'b0, 1'b0, 3,     16'h9999, 2'b11, 1'b1};
      vecs[13] = '{2'd3, 8'h00, 1'b1, 1'b0, 0,     16'h0000, 2'b00, 1'b0};
      vecs[14] = '{2'd3, 8'h00, 1'b0, 1'b1, 1,     16'h0000, 2'b11, 1'b1};
      vecs[15] = '{2'd2, 8'h00, 1'b1, 1'b0, 0,     16'h9999, 2'b00, 1'b0};
      vecs[16] = '{2'd2, 8'h00, 1'b0, 1'b1, 999,   16'h9000, 2'b01, 1'b0};
      vecs[17] = '{2'd2, 8'h00, 1'b0, 1'b0, 1,     16'h8999, 2'b01, 1'b0};
      vecs[18] = '{2'd3, 8'h10, 1'b1, 1'b0, 0,     16'h1000, 2'b00, 1'b0};
      vecs[19] = '{2'd3, 8'h10, 1'b0, 1'b1, 1,     16'h0999, 2'b01, 1'b0};

      rstN = 1'b0; countTick = 1'b0; scanTick = 1'b0; scanTick6 = 1'b0;
      startP = 1'b0; clearP = 1'b0; lapP = 1'b0; sel = 2'd0; load = 8'h00;
      repeat (3) cycle();
      rstN = 1'b1;
      checkCore("reset", 16'h0000, 2'b00, 1'b0);
      checkOutput("reset an", 32'(an), 32'h1);
      checkOutput("reset dp", 32'(dp), 32'h1);

      $display("[TB] scan walk on 4-digit preset 1200");
      sel = 2'd1; load = 8'h12;
      cycle();
      checkDisplay("scan1200", 16'h1200);
      checkDisplay("scanwrap", 16'h1200);

      $display("[TB] scan walk on 6-digit instance");
      for (int k = 0; k < 8; k++) begin
         expAn6 = 6'b000001 << (k % 6);
         checkOutput("scan6 an", 32'(an6), 32'(expAn6));
         checkOutput("scan6 dp", 32'(dp6), 32'(((k % 6) == 2) ? 1'b0 : 1'b1));
         if (k == 7) checkOutput("scan6 sseg", 32'(sseg6), 32'(segOf(4'd0)));
         scanTick6 = 1'b1; cycle(); scanTick6 = 1'b0;
      end

      $display("[TB] vector table");
      for (int i = 0; i < 20; i++) applyStimulus(i, vecs[i]);

      $display("[TB] start and tick coincidence");
      sel = 2'd0;
      pulseClear();
      pulseStart();
      ticks(3);
      checkCore("coin run", 16'h0003, 2'b01, 1'b0);
      startP = 1'b1; countTick = 1'b1; cycle(); startP = 1'b0; countTick = 1'b0;
      checkCore("coin pause", 16'h0003, 2'b10, 1'b0);
      startP = 1'b1; countTick = 1'b1; cycle(); startP = 1'b0; countTick = 1'b0;
      checkCore("coin resume", 16'h0003, 2'b01, 1'b0);
      ticks(1);
      checkCore("coin step", 16'h0004, 2'b01, 1'b0);
      clearP = 1'b1; startP = 1'b1; cycle(); clearP = 1'b0; startP = 1'b0;
      checkCore("clear beats start", 16'h0000, 2'b00, 1'b0);

      $display("[TB] lap hold");
      pulseStart();
      ticks(42);
      checkCore("lap base", 16'h0042, 2'b01, 1'b0);
      pulseLap();
      ticks(20);
      checkCore("lap running", 16'h0062, 2'b01, 1'b0);
`ifdef LAP_EN
      checkDisplay("lap held", 16'h0042);
`else
      checkDisplay("lap ignored", 16'h0062);
`endif
      pulseLap();
      checkDisplay("lap released", 16'h0062);

      $display("[TB] async reset mid-run");
      ticks(7);
      checkCore("pre reset", 16'h0069, 2'b01, 1'b0);
      scanStep();
      scanStep();
      #2 rstN = 1'b0;
      #1;
      checkCore("async reset", 16'h0000, 2'b00, 1'b0);
      checkOutput("async reset an", 32'(an), 32'h1);
      checkOutput("async reset dp", 32'(dp), 32'h1);
      scanIdx = 0;
      cycle();
      rstN = 1'b1;
      cycle();

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
